// File: rtl/opd_forward_pipe.sv
// Operand forwarding and load-use hazard unit: resolves NRD source operands against EX and a history of NSTAGE older writers.
// Latency: operand resolution and OF_stall are combinational; history, OF_err and OF_stall_cnt update on the clock edge.
// Backpressure: OF_stall requests that ID be held and a bubble be sent into EX; the history still shifts only when adv=1.
module opd_forward_pipe #(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int NRD    = 2,
  parameter int NSTAGE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv,
  input  logic [REGW-1:0]       EX_rd,
  input  logic                  EX_rd_vld,
  input  logic                  EX_rd_late,
  input  logic [XLEN-1:0]       EX_x_rd,
  input  logic                  LD_data_vld,
  input  logic [XLEN-1:0]       LD_data,
  input  logic [NRD*REGW-1:0]   REGS_rdaddr,
  input  logic [NRD-1:0]        REGS_rs_vld,
  input  logic [NRD*XLEN-1:0]   REGS_rddata,
  output logic [NRD*XLEN-1:0]   OF_x_rs,
  output logic                  OF_stall,
  output logic                  OF_err,
  output logic [31:0]           OF_stall_cnt
);

  typedef struct packed {
    logic            vld;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
    logic            rdy;
  } hist_t;

  hist_t             hist_q [NSTAGE];
  hist_t             hist_d [NSTAGE];
  logic [NSTAGE-1:0] pend_oh;
  logic              pend_seen;
  logic [NRD-1:0]    hazard;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;

  // One-hot marker of the oldest entry still waiting for its late data.
  always_comb begin
    pend_oh   = '0;
    pend_seen = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (!pend_seen && hist_q[i].vld && !hist_q[i].rdy) begin
        pend_oh[i] = 1'b1;
        pend_seen  = 1'b1;
      end
    end
  end

  // Per-port operand mux: walk oldest to youngest so the youngest match wins.
  always_comb begin
    OF_x_rs = REGS_rddata;
    hazard  = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int i = NSTAGE - 1; i >= 0; i--) begin
        if (hist_q[i].vld && (hist_q[i].rd == REGS_rdaddr[k*REGW +: REGW]) &&
            (REGS_rdaddr[k*REGW +: REGW] != '0)) begin
          if (hist_q[i].rdy) begin
            OF_x_rs[k*XLEN +: XLEN] = hist_q[i].data;
            hazard[k]               = 1'b0;
          end else if (pend_oh[i] && LD_data_vld) begin
            // Late data arriving this cycle is forwarded straight through.
            OF_x_rs[k*XLEN +: XLEN] = LD_data;
            hazard[k]               = 1'b0;
          end else begin
            OF_x_rs[k*XLEN +: XLEN] = REGS_rddata[k*XLEN +: XLEN];
            hazard[k]               = 1'b1;
          end
        end
      end
      if (EX_rd_vld && (EX_rd == REGS_rdaddr[k*REGW +: REGW]) &&
          (REGS_rdaddr[k*REGW +: REGW] != '0)) begin
        if (EX_rd_late) begin
          OF_x_rs[k*XLEN +: XLEN] = REGS_rddata[k*XLEN +: XLEN];
          hazard[k]               = 1'b1;
        end else begin
          OF_x_rs[k*XLEN +: XLEN] = EX_x_rd;
          hazard[k]               = 1'b0;
        end
      end
    end
  end

  assign OF_stall = |(hazard & REGS_rs_vld);

  // History next state: optional shift, then late-data capture at the post-shift slot.
  always_comb begin
    hist_d = hist_q;
    if (adv) begin
      hist_d[0].vld  = EX_rd_vld && (EX_rd != '0);
      hist_d[0].rd   = EX_rd;
      hist_d[0].data = EX_x_rd;
      hist_d[0].rdy  = !EX_rd_late;
      for (int i = 1; i < NSTAGE; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
    if (LD_data_vld) begin
      if (adv) begin
        // A pending entry in the last slot retires now; its capture is lost and flagged via OF_err.
        for (int j = 1; j < NSTAGE; j++) begin
          if (pend_oh[j-1]) begin
            hist_d[j].data = LD_data;
            hist_d[j].rdy  = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < NSTAGE; i++) begin
          if (pend_oh[i]) begin
            hist_d[i].data = LD_data;
            hist_d[i].rdy  = 1'b1;
          end
        end
      end
    end
  end

  // Sticky error and saturating stall counter next state.
  always_comb begin
    err_d = err_q | (adv & hist_q[NSTAGE-1].vld & ~hist_q[NSTAGE-1].rdy);
    cnt_d = cnt_q;
    if (OF_stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State registers; reset empties the history and drops any pending loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTAGE; i++) begin
        hist_q[i].vld  <= 1'b0;
        hist_q[i].rd   <= '0;
        hist_q[i].data <= '0;
        hist_q[i].rdy  <= 1'b1;
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        hist_q[i] <= hist_d[i];
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign OF_err       = err_q;
  assign OF_stall_cnt = cnt_q;

endmodule

// File: tb/tb_opd_forward_pipe.sv
// Self-checking bench for opd_forward_pipe: directed scenarios followed by random traffic.
// Expected values come from a queue-based model of the history kept in the bench.
// Outputs are sampled 1 time unit after input changes or after the rising edge.
module tb_opd_forward_pipe;
  localparam int XLEN   = 32;
  localparam int REGW   = 5;
  localparam int NRD    = 2;
  localparam int NSTAGE = 3;

  logic                clk;
  logic                rst_n;
  logic                adv;
  logic [REGW-1:0]     EX_rd;
  logic                EX_rd_vld;
  logic                EX_rd_late;
  logic [XLEN-1:0]     EX_x_rd;
  logic                LD_data_vld;
  logic [XLEN-1:0]     LD_data;
  logic [NRD*REGW-1:0] REGS_rdaddr;
  logic [NRD-1:0]      REGS_rs_vld;
  logic [NRD*XLEN-1:0] REGS_rddata;
  logic [NRD*XLEN-1:0] OF_x_rs;
  logic                OF_stall;
  logic                OF_err;
  logic [31:0]         OF_stall_cnt;

  opd_forward_pipe #(.XLEN(XLEN), .REGW(REGW), .NRD(NRD), .NSTAGE(NSTAGE)) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv),
    .EX_rd(EX_rd), .EX_rd_vld(EX_rd_vld), .EX_rd_late(EX_rd_late), .EX_x_rd(EX_x_rd),
    .LD_data_vld(LD_data_vld), .LD_data(LD_data),
    .REGS_rdaddr(REGS_rdaddr), .REGS_rs_vld(REGS_rs_vld), .REGS_rddata(REGS_rddata),
    .OF_x_rs(OF_x_rs), .OF_stall(OF_stall), .OF_err(OF_err), .OF_stall_cnt(OF_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              vld;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
    bit              rdy;
  } ent_t;

  ent_t        mh[$];   // index 0 = youngest writer
  bit          m_err;
  logic [31:0] m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    ent_t e;
    e.vld = 0; e.rd = '0; e.data = '0; e.rdy = 1;
    mh.delete();
    for (int i = 0; i < NSTAGE; i++) mh.push_back(e);
    m_err = 0;
    m_cnt = '0;
  endfunction

  function automatic int oldest_pend();
    for (int i = mh.size() - 1; i >= 0; i--)
      if (mh[i].vld && !mh[i].rdy) return i;
    return -1;
  endfunction

  // Youngest-first search: EX, then history, then the register file.
  function automatic void resolve(input int k, output logic [XLEN-1:0] val, output bit haz);
    logic [REGW-1:0] a;
    int p;
    a   = REGS_rdaddr[k*REGW +: REGW];
    val = REGS_rddata[k*XLEN +: XLEN];
    haz = 0;
    p   = oldest_pend();
    if (a == '0) return;
    if (EX_rd_vld && EX_rd == a) begin
      if (EX_rd_late) haz = 1; else val = EX_x_rd;
      return;
    end
    foreach (mh[i]) begin
      if (mh[i].vld && mh[i].rd == a) begin
        if (mh[i].rdy) val = mh[i].data;
        else if (i == p && LD_data_vld) val = LD_data;
        else haz = 1;
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    logic [XLEN-1:0] v;
    bit h;
    bit s;
    s = 0;
    for (int k = 0; k < NRD; k++) begin
      resolve(k, v, h);
      if (h && REGS_rs_vld[k]) s = 1;
    end
    return s;
  endfunction

  task automatic check_comb();
    logic [XLEN-1:0] v;
    bit h;
    #1;
    for (int k = 0; k < NRD; k++) begin
      resolve(k, v, h);
      chk($sformatf("x_rs[%0d]", k), OF_x_rs[k*XLEN +: XLEN], v);
    end
    chk("stall", OF_stall, model_stall());
  endtask

  task automatic tick();
    bit   st;
    int   p;
    ent_t e;
    st = model_stall();
    p  = oldest_pend();
    @(posedge clk);
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (adv) begin
      if (mh[NSTAGE-1].vld && !mh[NSTAGE-1].rdy) m_err = 1;
      void'(mh.pop_back());
      e.vld = EX_rd_vld && (EX_rd != '0); e.rd = EX_rd; e.data = EX_x_rd; e.rdy = !EX_rd_late;
      mh.push_front(e);
      if (p >= 0) p++;
    end
    if (LD_data_vld && p >= 0 && p < NSTAGE) begin
      e = mh[p]; e.data = LD_data; e.rdy = 1; mh[p] = e;
    end
    #1;
    chk("err", OF_err, m_err);
    chk("stall_cnt", OF_stall_cnt, m_cnt);
    @(negedge clk);
  endtask

  task automatic step();
    check_comb();
    tick();
  endtask

  task automatic set_ex(input bit v, input logic [REGW-1:0] rd, input bit late, input logic [XLEN-1:0] x);
    EX_rd_vld = v; EX_rd = rd; EX_rd_late = late; EX_x_rd = x;
  endtask

  task automatic set_port(input int k, input logic [REGW-1:0] a, input bit v, input logic [XLEN-1:0] d);
    REGS_rdaddr[k*REGW +: REGW] = a;
    REGS_rs_vld[k]              = v;
    REGS_rddata[k*XLEN +: XLEN] = d;
  endtask

  initial begin
    rst_n = 0; adv = 0; LD_data_vld = 0; LD_data = '0;
    set_ex(0, 0, 0, 0);
    set_port(0, 5'd3, 1, 32'h1234_5678);
    set_port(1, 5'd4, 1, 32'h9ABC_DEF0);
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_stall", OF_stall, 1'b0);
    chk("rst_err", OF_err, 1'b0);
    chk("rst_cnt", OF_stall_cnt, 32'd0);
    chk("rst_x_rs", OF_x_rs, REGS_rddata);
    @(negedge clk);
    rst_n = 1;
    step();

    // Priority: hist[1]=x5:0x33, hist[0]=x5:0x22, EX x5:0x11.
    set_port(0, 5'd5, 1, 32'h55); set_port(1, 5'd0, 0, 32'h0);
    adv = 1;
    set_ex(1, 5'd5, 0, 32'h33); step();
    set_ex(1, 5'd5, 0, 32'h22); step();
    adv = 0;
    set_ex(1, 5'd5, 0, 32'h11);
    check_comb();
    chk("prio_ex", OF_x_rs[31:0], 32'h11);
    tick();
    set_ex(0, 5'd5, 0, 32'h11);
    check_comb();
    chk("prio_hist0", OF_x_rs[31:0], 32'h22);
    tick();

    // x0 never forwards.
    adv = 1;
    set_ex(1, 5'd0, 0, 32'hDEAD);
    set_port(0, 5'd0, 1, 32'h0); set_port(1, 5'd0, 1, 32'h0);
    check_comb();
    chk("x0_port0", OF_x_rs[31:0], 32'h0);
    chk("x0_port1", OF_x_rs[63:32], 32'h0);
    chk("x0_stall", OF_stall, 1'b0);
    tick();

    // Load-use on port 1.
    set_port(0, 5'd0, 0, 32'h0); set_port(1, 5'd7, 1, 32'h77);
    set_ex(1, 5'd7, 1, 32'hBAD0_BAD0);
    adv = 1;
    check_comb();
    chk("lu_stall_ex", OF_stall, 1'b1);
    tick();
    set_ex(0, 5'd0, 0, 32'h0);
    adv = 0;
    check_comb();
    chk("lu_stall_hist", OF_stall, 1'b1);
    tick();
    LD_data_vld = 1; LD_data = 32'hCAFE_0001;
    check_comb();
    chk("lu_fwd", OF_x_rs[63:32], 32'hCAFE_0001);
    chk("lu_nostall", OF_stall, 1'b0);
    chk("lu_cnt", OF_stall_cnt, 32'd2);
    tick();
    LD_data_vld = 0;
    check_comb();
    chk("lu_captured", OF_x_rs[63:32], 32'hCAFE_0001);
    tick();

    // Unused port: pending x7 only read on a port with rs_vld=0.
    set_port(0, 5'd7, 0, 32'h7007); set_port(1, 5'd3, 1, 32'h3003);
    set_ex(1, 5'd7, 1, 32'h0);
    adv = 1;
    check_comb();
    chk("unused_ex", OF_stall, 1'b0);
    tick();
    set_ex(0, 5'd0, 0, 32'h0);
    adv = 0;
    check_comb();
    chk("unused_hist", OF_stall, 1'b0);
    tick();

    // Late return: the pending load sits in hist[0]; three advances retire it.
    adv = 1;
    step();
    step();
    chk("late_err_before", OF_err, 1'b0);
    step();
    chk("late_err_set", OF_err, 1'b1);
    adv = 0;
    LD_data_vld = 1; LD_data = 32'h1111_2222;
    step();
    LD_data_vld = 0;
    step();
    chk("late_err_sticky", OF_err, 1'b1);

    // Reset mid-stall with a pending load in the history.
    set_ex(1, 5'd9, 1, 32'h0);
    adv = 1;
    set_port(0, 5'd9, 1, 32'hA5A5_0009); set_port(1, 5'd5, 1, 32'h5A5A_0005);
    step();
    set_ex(0, 5'd0, 0, 32'h0);
    adv = 0;
    check_comb();
    chk("mid_stall", OF_stall, 1'b1);
    rst_n = 0;
    #1;
    model_reset();
    chk("mrst_stall", OF_stall, 1'b0);
    chk("mrst_err", OF_err, 1'b0);
    chk("mrst_cnt", OF_stall_cnt, 32'd0);
    chk("mrst_x_rs", OF_x_rs, REGS_rddata);
    @(negedge clk);
    rst_n = 1;
    check_comb();
    chk("post_rst_x_rs", OF_x_rs, REGS_rddata);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      adv         = ($urandom_range(0, 9) < 7);
      LD_data_vld = ($urandom_range(0, 9) < 3);
      LD_data     = $urandom;
      set_ex($urandom_range(0, 9) < 7, REGW'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 3, $urandom);
      for (int k = 0; k < NRD; k++)
        set_port(k, REGW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
